// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences manual writes and a fill/verify self-test for a synchronous memory.
// Reads are pipelined: mem_dout for an address is compared two edges after that address is registered.
module mem_access_ctrl #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              wr_pulse,
   input  logic              fill_start,
   input  logic              auto_inc,
   input  logic [ADDR_W-1:0] sw_addr,
   input  logic [DATA_W-1:0] sw_data,
   input  logic [DATA_W-1:0] mem_dout,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   output logic              busy,
   output logic              done,
   output logic              err_flag,
   output logic [ADDR_W:0]   err_count,
   output logic [ADDR_W-1:0] first_err_addr
);
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_FILL = 3'd1;
   localparam logic [2:0] S_VERIFY = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;
   localparam logic [ADDR_W-1:0] A_ONE = 1;
   localparam logic [ADDR_W-1:0] A_LAST = '1;
   localparam logic [ADDR_W:0] C_ONE = 1;
   localparam logic [ADDR_W:0] C_MAX = '1;

   logic [2:0]        r_state;
   logic [ADDR_W-1:0] r_ptr, r_cnt, r_tag, r_mem_addr, r_first;
   logic [DATA_W-1:0] r_seed, r_mem_din;
   logic              r_rd, r_cmp_v, r_mem_we, r_busy, r_done, r_err_flag;
   logic [ADDR_W:0]   r_err_count;
   logic              w_mis;

   assign w_mis = r_cmp_v && (mem_dout != (DATA_W'(r_tag) ^ r_seed));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_ptr       <= '0;
         r_cnt       <= '0;
         r_tag       <= '0;
         r_seed      <= '0;
         r_rd        <= 1'b0;
         r_cmp_v     <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_din   <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err_flag  <= 1'b0;
         r_err_count <= '0;
         r_first     <= '0;
      end else begin
         r_done  <= 1'b0;
         r_rd    <= 1'b0;
         r_cmp_v <= r_rd;
         r_tag   <= r_mem_addr;
         if (w_mis) begin
            r_err_count <= (r_err_count == C_MAX) ? r_err_count : r_err_count + C_ONE;
            if (!r_err_flag) begin
               r_err_flag <= 1'b1;
               r_first    <= r_tag;
            end
         end
         case (r_state)
            S_IDLE: begin
               r_mem_we   <= wr_pulse && !fill_start;
               r_mem_addr <= r_ptr;
               r_mem_din  <= (wr_pulse && !fill_start) ? sw_data : r_mem_din;
               r_ptr      <= auto_inc ? r_ptr + ((wr_pulse && !fill_start) ? A_ONE : '0) : sw_addr;
               if (fill_start) begin
                  r_seed      <= sw_data;
                  r_cnt       <= '0;
                  r_busy      <= 1'b1;
                  r_err_flag  <= 1'b0;
                  r_err_count <= '0;
                  r_first     <= '0;
                  r_state     <= S_FILL;
               end
            end
            S_FILL: begin
               r_mem_we   <= 1'b1;
               r_mem_addr <= r_cnt;
               r_mem_din  <= DATA_W'(r_cnt) ^ r_seed;
               r_cnt      <= r_cnt + A_ONE;
               r_state    <= (r_cnt == A_LAST) ? S_VERIFY : S_FILL;
            end
            S_VERIFY: begin
               r_mem_we   <= 1'b0;
               r_mem_addr <= r_cnt;
               r_rd       <= 1'b1;
               r_cnt      <= r_cnt + A_ONE;
               r_state    <= (r_cnt == A_LAST) ? S_DRAIN : S_VERIFY;
            end
            S_DRAIN: r_state <= S_DONE;
            S_DONE: begin
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign mem_we         = r_mem_we;
   assign mem_addr       = r_mem_addr;
   assign mem_din        = r_mem_din;
   assign busy           = r_busy;
   assign done           = r_done;
   assign err_flag       = r_err_flag;
   assign err_count      = r_err_count;
   assign first_err_addr = r_first;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: randomized bench with a behavioural memory that can corrupt chosen read words.
module tb_mem_access_ctrl;
   localparam int AW = 4;
   localparam int DW = 4;
   localparam int N = 1 << AW;

   logic clk = 1'b0, reset_n = 1'b0;
   logic wr_pulse = 1'b0, fill_start = 1'b0, auto_inc = 1'b0;
   logic [AW-1:0] sw_addr = '0;
   logic [DW-1:0] sw_data = '0;
   logic [DW-1:0] mem_dout;
   logic mem_we, busy, done, err_flag;
   logic [AW-1:0] mem_addr, first_err_addr;
   logic [DW-1:0] mem_din;
   logic [AW:0] err_count;

   logic [DW-1:0] mem [N];
   logic [DW-1:0] flt [N];
   logic [DW-1:0] rd_q;
   logic [AW-1:0] rd_a;
   int npass = 0, ntot = 0;

   always #5 clk = ~clk;

   // Synchronous memory: address captured on an edge, data visible the following cycle, optionally corrupted.
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_din;
      rd_q <= mem[mem_addr];
      rd_a <= mem_addr;
   end
   assign mem_dout = rd_q ^ flt[rd_a];

   mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .reset_n(reset_n), .wr_pulse(wr_pulse), .fill_start(fill_start),
      .auto_inc(auto_inc), .sw_addr(sw_addr), .sw_data(sw_data), .mem_dout(mem_dout),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .busy(busy), .done(done),
      .err_flag(err_flag), .err_count(err_count), .first_err_addr(first_err_addr)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #3;
      ntot++; if ({mem_we, mem_addr, mem_din, busy, done, err_flag, err_count, first_err_addr} !== '0)
         $display("FAIL reset_outputs got we=%0d addr=%0d din=%0d busy=%0d done=%0d ef=%0d ec=%0d fa=%0d want all 0",
                  mem_we, mem_addr, mem_din, busy, done, err_flag, err_count, first_err_addr); else npass++;
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_manual_write();
      auto_inc = 1'b0; sw_addr = 4'd5; sw_data = 4'hA;
      tick();
      wr_pulse = 1'b1;
      tick();
      wr_pulse = 1'b0;
      ntot++; if ({mem_we, mem_addr, mem_din} !== {1'b1, 4'd5, 4'hA})
         $display("FAIL manual_write got we=%0d addr=%0d din=%0h want 1/5/a", mem_we, mem_addr, mem_din); else npass++;
      tick();
      ntot++; if (mem_we !== 1'b0) $display("FAIL manual_we_pulse got %0d want 0", mem_we); else npass++;
      tick();
      ntot++; if (mem_dout !== 4'hA) $display("FAIL manual_readback got %0h want a", mem_dout); else npass++;
   endtask

   task automatic test_random_writes();
      logic [DW-1:0] ref_mem [N];
      logic [AW-1:0] a;
      for (int i = 0; i < N; i++) ref_mem[i] = mem[i];
      auto_inc = 1'b0;
      for (int i = 0; i < 10; i++) begin
         a = AW'($urandom_range(N - 1));
         sw_addr = a; sw_data = DW'($urandom_range(15));
         tick();
         wr_pulse = 1'b1;
         tick();
         wr_pulse = 1'b0;
         ref_mem[a] = sw_data;
         ntot++; if ({mem_we, mem_addr, mem_din} !== {1'b1, a, sw_data})
            $display("FAIL rand_write got we=%0d addr=%0d din=%0h want 1/%0d/%0h", mem_we, mem_addr, mem_din, a, sw_data); else npass++;
      end
      for (int i = 0; i < 6; i++) begin
         a = AW'($urandom_range(N - 1));
         sw_addr = a;
         tick(); tick(); tick();
         ntot++; if (mem_dout !== ref_mem[a])
            $display("FAIL rand_read addr=%0d got %0h want %0h", a, mem_dout, ref_mem[a]); else npass++;
      end
   endtask

   task automatic test_auto_inc();
      logic [AW-1:0] exp_a [3];
      exp_a[0] = 4'd14; exp_a[1] = 4'd15; exp_a[2] = 4'd0;
      auto_inc = 1'b0; sw_addr = 4'd14;
      tick(); tick();
      auto_inc = 1'b1; sw_addr = 4'd7;
      for (int i = 0; i < 3; i++) begin
         sw_data = DW'(i + 1); wr_pulse = 1'b1;
         tick();
         wr_pulse = 1'b0;
         ntot++; if ({mem_we, mem_addr, mem_din} !== {1'b1, exp_a[i], DW'(i + 1)})
            $display("FAIL auto_inc_write%0d got we=%0d addr=%0d din=%0d want 1/%0d/%0d", i, mem_we, mem_addr, mem_din, exp_a[i], i + 1); else npass++;
      end
      tick(); tick();
      ntot++; if ({mem_we, mem_addr} !== {1'b0, 4'd1})
         $display("FAIL auto_inc_ptr got we=%0d addr=%0d want 0/1", mem_we, mem_addr); else npass++;
   endtask

   task automatic test_selftest(input logic [DW-1:0] seed, input bit disturb);
      int cyc, ecnt;
      logic [AW-1:0] efirst, ptr0;
      ecnt = 0; efirst = '0;
      for (int a = N - 1; a >= 0; a--) if (flt[a] != '0) begin ecnt++; efirst = AW'(a); end
      ptr0 = mem_addr;
      sw_data = seed; fill_start = 1'b1; wr_pulse = disturb;
      tick();
      fill_start = 1'b0; wr_pulse = 1'b0; cyc = 1;
      ntot++; if ({mem_we, busy} !== 2'b01) $display("FAIL st_entry got we=%0d busy=%0d want 0/1", mem_we, busy); else npass++;
      for (int k = 0; k < N; k++) begin
         if (disturb && k == 5) begin wr_pulse = 1'b1; fill_start = 1'b1; sw_data = ~seed; end
         tick();
         wr_pulse = 1'b0; fill_start = 1'b0; cyc++;
         ntot++; if ({mem_we, mem_addr, mem_din} !== {1'b1, AW'(k), DW'(k) ^ seed})
            $display("FAIL st_fill%0d got we=%0d addr=%0d din=%0h want 1/%0d/%0h", k, mem_we, mem_addr, mem_din, k, DW'(k) ^ seed); else npass++;
      end
      while (done !== 1'b1 && cyc < 200) begin
         if (disturb && cyc == 25) begin wr_pulse = 1'b1; fill_start = 1'b1; end
         tick();
         wr_pulse = 1'b0; fill_start = 1'b0; cyc++;
      end
      ntot++; if (cyc != 2 * N + 3) $display("FAIL st_latency got %0d want %0d", cyc, 2 * N + 3); else npass++;
      ntot++; if ({busy, err_flag, err_count, first_err_addr} !== {1'b0, ecnt != 0, (AW + 1)'(ecnt), efirst})
         $display("FAIL st_result got busy=%0d ef=%0d ec=%0d fa=%0d want 0/%0d/%0d/%0d",
                  busy, err_flag, err_count, first_err_addr, ecnt != 0, ecnt, efirst); else npass++;
      tick();
      ntot++; if ({done, err_count, first_err_addr, mem_we, mem_addr} !== {1'b0, (AW + 1)'(ecnt), efirst, 1'b0, ptr0})
         $display("FAIL st_after got done=%0d ec=%0d fa=%0d we=%0d addr=%0d want 0/%0d/%0d/0/%0d",
                  done, err_count, first_err_addr, mem_we, mem_addr, ecnt, efirst, ptr0); else npass++;
      for (int a = 0; a < N; a++) begin
         ntot++; if (mem[a] !== (DW'(a) ^ seed)) $display("FAIL st_contents addr=%0d got %0h want %0h", a, mem[a], DW'(a) ^ seed); else npass++;
      end
   endtask

   task automatic test_reset_mid_fill();
      sw_data = 4'h6; fill_start = 1'b1;
      tick();
      fill_start = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      #2 reset_n = 1'b0;
      #1;
      ntot++; if ({mem_we, mem_addr, mem_din, busy, done, err_flag, err_count, first_err_addr} !== '0)
         $display("FAIL midfill_reset got we=%0d addr=%0d din=%0d busy=%0d done=%0d want all 0", mem_we, mem_addr, mem_din, busy, done); else npass++;
      tick();
      reset_n = 1'b1; auto_inc = 1'b0; sw_addr = 4'd2; sw_data = 4'h9;
      tick(); tick();
      wr_pulse = 1'b1;
      tick();
      wr_pulse = 1'b0;
      ntot++; if ({mem_we, mem_addr, mem_din} !== {1'b1, 4'd2, 4'h9})
         $display("FAIL post_reset_write got we=%0d addr=%0d din=%0h want 1/2/9", mem_we, mem_addr, mem_din); else npass++;
      tick();
   endtask

   initial begin
      logic [DW-1:0] s;
      for (int a = 0; a < N; a++) begin mem[a] = '0; flt[a] = '0; end
      test_reset();
      test_manual_write();
      test_auto_inc();
      test_random_writes();
      test_selftest(4'h3, 1'b0);
      flt[6] = 4'h1; flt[9] = 4'h1;
      test_selftest(4'h3, 1'b0);
      for (int a = 0; a < N; a++) flt[a] = '0;
      auto_inc = 1'b1;
      test_selftest(4'hC, 1'b1);
      auto_inc = 1'b0;
      for (int r = 0; r < 3; r++) begin
         for (int a = 0; a < N; a++) flt[a] = ($urandom_range(3) == 0) ? DW'($urandom_range(1, 15)) : '0;
         s = DW'($urandom_range(15));
         test_selftest(s, 1'b0);
      end
      for (int a = 0; a < N; a++) flt[a] = '0;
      test_reset_mid_fill();
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule
